// File: rtl/hdc_ngram_encoder.sv
// N-gram hypervector encoder: each symbol's item vector is rotated by its position and XOR-bound into the n-gram.
// Optional macro HDC_WR_BYPASS_EN makes the item-memory read write-first instead of read-first.
module hdc_ngram_encoder #(
  parameter  int DIM        = 1024,
  parameter  int ITEM_DEPTH = 1024,
  parameter  int NGRAM_MAX  = 16,
  localparam int AW         = (ITEM_DEPTH > 1) ? $clog2(ITEM_DEPTH) : 1,
  localparam int PW         = $clog2(NGRAM_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DIM-1:0] wr_data,
  input  logic [PW-1:0]  ngram_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  in_addr,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DIM-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    ACC,
    OUT
  } state_e;

  state_e         r_state;
  state_e         w_nextState;

  logic [DIM-1:0] r_mem [ITEM_DEPTH];
  logic [AW-1:0]  r_addr;
  logic           r_last;
  logic [PW-1:0]  r_pos;
  logic [PW-1:0]  r_len;
  logic [DIM-1:0] r_hv;
  logic [DIM-1:0] r_enc;

  logic [PW-1:0]  w_lenEff;
  logic           w_wrInRange;
  logic           w_rdInRange;
  logic [DIM-1:0] w_rdData;
  logic [DIM-1:0] w_rot;
  logic           w_close;

  assign w_wrInRange = (32'(wr_addr) < 32'(ITEM_DEPTH));
  assign w_rdInRange = (32'(r_addr) < 32'(ITEM_DEPTH));
  assign w_close     = r_last || ((r_pos + PW'(1)) == r_len);

  // Zero length means a single-symbol n-gram; anything above NGRAM_MAX saturates.
  always_comb begin
    w_lenEff = ngram_len;
    if (ngram_len == '0) begin
      w_lenEff = PW'(1);
    end else if (ngram_len > PW'(NGRAM_MAX)) begin
      w_lenEff = PW'(NGRAM_MAX);
    end
  end

  // Item memory has no reset so stored vectors survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && w_wrInRange) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_rdData = '0;
    if (w_rdInRange) begin
`ifdef HDC_WR_BYPASS_EN
      w_rdData = (wr_en && (wr_addr == r_addr)) ? wr_data : r_mem[r_addr];
`else
      w_rdData = r_mem[r_addr];
`endif
    end
  end

  // Log-depth barrel rotator: stage k rotates right by 2^k (mod DIM) when pos bit k is set.
  logic [DIM-1:0] w_stage [PW+1];
  assign w_stage[0] = r_hv;

  for (genvar k = 0; k < PW; k++) begin : g_rot
    localparam int SH = (2 ** k) % DIM;
    if (SH == 0) begin : g_pass
      assign w_stage[k+1] = w_stage[k];
    end else begin : g_shift
      assign w_stage[k+1] = r_pos[k] ? {w_stage[k][SH-1:0], w_stage[k][DIM-1:SH]}
                                     : w_stage[k];
    end
  end

  assign w_rot = w_stage[PW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    unique case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          w_nextState = READ;
        end
      end
      READ: begin
        w_nextState = ACC;
      end
      ACC: begin
        w_nextState = w_close ? OUT : IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = r_enc;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Length is latched only when a new n-gram begins, so mid-gram changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_last <= 1'b0;
      r_pos  <= '0;
      r_len  <= PW'(1);
      r_hv   <= '0;
      r_enc  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_addr <= in_addr;
            r_last <= in_last;
            if (r_pos == '0) begin
              r_len <= w_lenEff;
            end
          end
        end
        READ: begin
          r_hv <= w_rdData;
        end
        ACC: begin
          r_enc <= (r_pos == '0) ? w_rot : (r_enc ^ w_rot);
          r_pos <= w_close ? '0 : (r_pos + PW'(1));
        end
        default: begin
        end
      endcase
    end
  end

endmodule
